// File: rtl/axi_rd_xbar_pkg.sv
// Shared constants and types for the AXI read crossbar.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_rd_xbar_pkg;

  // AXI read response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Crossbar control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DERR = 2'd3
  } state_t;

  // Default address map, one 16-bit ARADDR[31:16] region per slave, slave 0 in the low bits:
  // ROM 0x0000, IM 0x0001, DM 0x0002, sensor 0x1000, DRAM 0x2000-0x201F
  localparam logic [5*16-1:0] SLV_LO_DEF = {16'h2000, 16'h1000, 16'h0002, 16'h0001, 16'h0000};
  localparam logic [5*16-1:0] SLV_HI_DEF = {16'h201F, 16'h1000, 16'h0002, 16'h0001, 16'h0000};

endpackage

// File: rtl/axi_rd_xbar_rr_arbiter.sv
// Round-robin requester selection with a pointer advanced on burst completion.
// Latency: grant is combinational from req; pointer updates one cycle after advance.
// Backpressure: none; the pointer only moves when the owner reports completion.
module axi_rd_xbar_rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [PW-1:0] done_idx,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [PW-1:0] rr_ptr;

  // Pointer moves to the requester after the one that just finished
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (done_idx == PW'(N - 1)) ? '0 : done_idx + 1'b1;
    end
  end

  // First pass searches rr_ptr..N-1, second pass wraps to 0..rr_ptr-1
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!gnt_vld && req[j] && (j >= int'(rr_ptr))) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!gnt_vld && req[j] && (j < int'(rr_ptr))) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/axi_rd_xbar.sv
// NM-master to NS-slave AXI read crossbar, one burst in flight, round-robin grant held per burst.
// Latency: AR accept to ARVALID_S is 1 cycle; R channel is a combinational pass-through.
// Backpressure: ARREADY_S stalls in ADDR, RREADY_M is forwarded to RREADY_S; AXI_RD_XBAR_PERF_EN adds counters.
module axi_rd_xbar
  import axi_rd_xbar_pkg::*;
#(
  parameter int NM        = 2,
  parameter int NS        = 5,
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter logic [NS*16-1:0] SLV_LO = SLV_LO_DEF,
  parameter logic [NS*16-1:0] SLV_HI = SLV_HI_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef AXI_RD_XBAR_PERF_EN
  output logic [NM*16-1:0]        burst_cnt_o,
  output logic [NM*16-1:0]        stall_cnt_o,
`endif
  input  logic [NM*ID_BITS-1:0]   ARID_M,
  input  logic [NM*ADDR_BITS-1:0] ARADDR_M,
  input  logic [NM*LEN_BITS-1:0]  ARLEN_M,
  input  logic [NM*SIZE_BITS-1:0] ARSIZE_M,
  input  logic [NM*2-1:0]         ARBURST_M,
  input  logic [NM-1:0]           ARVALID_M,
  output logic [NM-1:0]           ARREADY_M,
  output logic [NM*ID_BITS-1:0]   RID_M,
  output logic [NM*DATA_BITS-1:0] RDATA_M,
  output logic [NM*2-1:0]         RRESP_M,
  output logic [NM-1:0]           RLAST_M,
  output logic [NM-1:0]           RVALID_M,
  input  logic [NM-1:0]           RREADY_M,
  output logic [NS*IDS_BITS-1:0]  ARID_S,
  output logic [NS*ADDR_BITS-1:0] ARADDR_S,
  output logic [NS*LEN_BITS-1:0]  ARLEN_S,
  output logic [NS*SIZE_BITS-1:0] ARSIZE_S,
  output logic [NS*2-1:0]         ARBURST_S,
  output logic [NS-1:0]           ARVALID_S,
  input  logic [NS-1:0]           ARREADY_S,
  input  logic [NS*IDS_BITS-1:0]  RID_S,
  input  logic [NS*DATA_BITS-1:0] RDATA_S,
  input  logic [NS*2-1:0]         RRESP_S,
  input  logic [NS-1:0]           RLAST_S,
  input  logic [NS-1:0]           RVALID_S,
  output logic [NS-1:0]           RREADY_S
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  state_t state_q, state_d;

  // Latched burst context
  logic [ID_BITS-1:0]   id_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [SIZE_BITS-1:0] size_q;
  logic [1:0]           burst_q;
  logic [GW-1:0]        g_q;
  logic [SW-1:0]        s_q;
  logic [LEN_BITS-1:0]  beat_q;

  logic [NM-1:0] gnt;
  logic [GW-1:0] gnt_idx;
  logic          gnt_vld;
  logic          accept, advance, derr_hs;

  logic [ID_BITS-1:0]   req_id;
  logic [ADDR_BITS-1:0] req_addr;
  logic [LEN_BITS-1:0]  req_len;
  logic [SIZE_BITS-1:0] req_size;
  logic [1:0]           req_burst;
  logic                 dec_hit;
  logic [SW-1:0]        dec_idx;

  logic                 s_arready, s_rvalid, s_rlast, m_rready;
  logic [DATA_BITS-1:0] s_rdata;
  logic [1:0]           s_rresp;
  logic [ID_BITS-1:0]   s_rid;
  logic                 derr_last;

  // Upper slave-side ID bits carry the master index, already known from g_q
  logic unused_rid;
  assign unused_rid = ^RID_S;

  assign derr_last = (beat_q == len_q);

  axi_rd_xbar_rr_arbiter #(.N(NM)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (ARVALID_M),
    .advance  (advance),
    .done_idx (g_q),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  // Pick the AR payload of the master the arbiter is offering a grant to
  always_comb begin
    req_id    = '0;
    req_addr  = '0;
    req_len   = '0;
    req_size  = '0;
    req_burst = '0;
    for (int m = 0; m < NM; m++) begin
      if (gnt_idx == GW'(m)) begin
        req_id    = ARID_M[m*ID_BITS +: ID_BITS];
        req_addr  = ARADDR_M[m*ADDR_BITS +: ADDR_BITS];
        req_len   = ARLEN_M[m*LEN_BITS +: LEN_BITS];
        req_size  = ARSIZE_M[m*SIZE_BITS +: SIZE_BITS];
        req_burst = ARBURST_M[m*2 +: 2];
      end
    end
  end

  // Address decode; scanning downward lets the lowest matching slave win
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((req_addr[ADDR_BITS-1 -: 16] >= SLV_LO[i*16 +: 16]) &&
          (req_addr[ADDR_BITS-1 -: 16] <= SLV_HI[i*16 +: 16])) begin
        dec_hit = 1'b1;
        dec_idx = SW'(i);
      end
    end
  end

  // Gather the selected slave's response lines and the owning master's ready
  always_comb begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rid     = '0;
    m_rready  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (s_q == SW'(i)) begin
        s_arready = ARREADY_S[i];
        s_rvalid  = RVALID_S[i];
        s_rlast   = RLAST_S[i];
        s_rdata   = RDATA_S[i*DATA_BITS +: DATA_BITS];
        s_rresp   = RRESP_S[i*2 +: 2];
        s_rid     = RID_S[i*IDS_BITS +: ID_BITS];
      end
    end
    for (int m = 0; m < NM; m++) begin
      if (g_q == GW'(m)) m_rready = RREADY_M[m];
    end
  end

  // Next-state logic and handshake strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    derr_hs = 1'b0;
    case (state_q)
      IDLE: if (gnt_vld) begin
        accept  = 1'b1;
        state_d = dec_hit ? ADDR : DERR;
      end
      ADDR: if (s_arready) state_d = DATA;
      DATA: if (s_rvalid && m_rready && s_rlast) begin
        state_d = IDLE;
        advance = 1'b1;
      end
      DERR: if (m_rready) begin
        derr_hs = 1'b1;
        if (derr_last) begin
          state_d = IDLE;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and burst context capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      g_q     <= '0;
      s_q     <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q    <= req_id;
        addr_q  <= req_addr;
        len_q   <= req_len;
        size_q  <= req_size;
        burst_q <= req_burst;
        g_q     <= gnt_idx;
        s_q     <= dec_idx;
        beat_q  <= '0;
      end else if (derr_hs) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Port steering; everything is forced low while rst is high
  always_comb begin
    ARREADY_M = '0;
    RID_M     = '0;
    RDATA_M   = '0;
    RRESP_M   = '0;
    RLAST_M   = '0;
    RVALID_M  = '0;
    ARID_S    = '0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARSIZE_S  = '0;
    ARBURST_S = '0;
    ARVALID_S = '0;
    RREADY_S  = '0;
    if (!rst) begin
      case (state_q)
        IDLE: ARREADY_M = gnt;
        ADDR: begin
          for (int i = 0; i < NS; i++) begin
            if (s_q == SW'(i)) begin
              ARVALID_S[i]                       = 1'b1;
              ARID_S[i*IDS_BITS +: IDS_BITS]     = IDS_BITS'({g_q, id_q});
              ARADDR_S[i*ADDR_BITS +: ADDR_BITS] = addr_q;
              ARLEN_S[i*LEN_BITS +: LEN_BITS]    = len_q;
              ARSIZE_S[i*SIZE_BITS +: SIZE_BITS] = size_q;
              ARBURST_S[i*2 +: 2]                = burst_q;
            end
          end
        end
        DATA: begin
          for (int m = 0; m < NM; m++) begin
            if (g_q == GW'(m)) begin
              RVALID_M[m]                        = s_rvalid;
              RLAST_M[m]                         = s_rlast;
              RID_M[m*ID_BITS +: ID_BITS]        = s_rid;
              RDATA_M[m*DATA_BITS +: DATA_BITS]  = s_rdata;
              RRESP_M[m*2 +: 2]                  = s_rresp;
            end
          end
          for (int i = 0; i < NS; i++) begin
            if (s_q == SW'(i)) RREADY_S[i] = m_rready;
          end
        end
        DERR: begin
          for (int m = 0; m < NM; m++) begin
            if (g_q == GW'(m)) begin
              RVALID_M[m]                 = 1'b1;
              RLAST_M[m]                  = derr_last;
              RID_M[m*ID_BITS +: ID_BITS] = id_q;
              RRESP_M[m*2 +: 2]           = DECERR;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_RD_XBAR_PERF_EN
  // Saturating per-master completed-burst and AR-stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int m = 0; m < NM; m++) begin
        if (advance && (g_q == GW'(m)) && (burst_cnt_o[m*16 +: 16] != 16'hFFFF))
          burst_cnt_o[m*16 +: 16] <= burst_cnt_o[m*16 +: 16] + 16'd1;
        if (ARVALID_M[m] && !ARREADY_M[m] && (stall_cnt_o[m*16 +: 16] != 16'hFFFF))
          stall_cnt_o[m*16 +: 16] <= stall_cnt_o[m*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_xbar.sv
// Directed bench for axi_rd_xbar: table of single bursts plus reset, contention and mid-burst reset sequences.
// Latency: inputs driven 1ns after posedge, outputs sampled 2ns after posedge.
// Backpressure: RREADY_M is toggled on selected bursts; slave ARREADY is held off for one cycle per burst.
module tb_axi_rd_xbar;

  localparam int NM = 2, NS = 5, IDB = 4, IDSB = 8, AB = 32, DB = 32, LB = 4, SB = 3;

  logic clk = 1'b0;
  logic rst;

  logic [NM*IDB-1:0]  ARID_M;
  logic [NM*AB-1:0]   ARADDR_M;
  logic [NM*LB-1:0]   ARLEN_M;
  logic [NM*SB-1:0]   ARSIZE_M;
  logic [NM*2-1:0]    ARBURST_M;
  logic [NM-1:0]      ARVALID_M, ARREADY_M;
  logic [NM*IDB-1:0]  RID_M;
  logic [NM*DB-1:0]   RDATA_M;
  logic [NM*2-1:0]    RRESP_M;
  logic [NM-1:0]      RLAST_M, RVALID_M, RREADY_M;
  logic [NS*IDSB-1:0] ARID_S;
  logic [NS*AB-1:0]   ARADDR_S;
  logic [NS*LB-1:0]   ARLEN_S;
  logic [NS*SB-1:0]   ARSIZE_S;
  logic [NS*2-1:0]    ARBURST_S;
  logic [NS-1:0]      ARVALID_S, ARREADY_S;
  logic [NS*IDSB-1:0] RID_S;
  logic [NS*DB-1:0]   RDATA_S;
  logic [NS*2-1:0]    RRESP_S;
  logic [NS-1:0]      RLAST_S, RVALID_S, RREADY_S;

  int errors = 0;
  int checks = 0;

  axi_rd_xbar dut (
    .clk(clk), .rst(rst),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;     // requesting master
    logic [31:0] addr;
    int          len;   // ARLEN
    logic [3:0]  id;
    int          s;     // expected slave, -1 for decode error
    bit          tog;   // toggle RREADY_M during the data phase
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ar(input int m, input logic [31:0] addr, input int len, input logic [3:0] id);
    ARID_M[m*IDB +: IDB]   = id;
    ARADDR_M[m*AB +: AB]   = addr;
    ARLEN_M[m*LB +: LB]    = LB'(len);
    ARSIZE_M[m*SB +: SB]   = 3'd2;
    ARBURST_M[m*2 +: 2]    = 2'b01;
  endtask

  // Entered 1ns after posedge; returns 1ns after the accepting posedge
  task automatic ar_phase(input int m, input logic [31:0] addr, input int len, input logic [3:0] id,
                          input bit keep, output int w);
    set_ar(m, addr, len, id);
    ARVALID_M[m] = 1'b1;
    #1;
    w = 0;
    while (ARREADY_M == '0 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ar_grant", 64'(ARREADY_M), 64'(1) << m);
    @(posedge clk); #1;
    if (!keep) ARVALID_M[m] = 1'b0;
  endtask

  task automatic addr_phase(input int m, input logic [31:0] addr, input int len, input logic [3:0] id,
                            input int s);
    logic [7:0] exp_id;
    exp_id = 8'((m << 4) | int'(id));
    #1;
    chk("arvalid_s", 64'(ARVALID_S), 64'(1) << s);
    chk("arid_s", 64'(ARID_S[s*IDSB +: IDSB]), 64'(exp_id));
    chk("araddr_s", 64'(ARADDR_S[s*AB +: AB]), 64'(addr));
    chk("arlen_s", 64'(ARLEN_S[s*LB +: LB]), 64'(len));
    chk("arsize_burst_s", 64'({ARSIZE_S[s*SB +: SB], ARBURST_S[s*2 +: 2]}), 64'({3'd2, 2'b01}));
    chk("arready_m_addr", 64'(ARREADY_M), 64'(0));
    chk("rvalid_m_addr", 64'(RVALID_M), 64'(0));
    @(posedge clk); #1;
    chk("arvalid_s_hold", 64'(ARVALID_S), 64'(1) << s);
    chk("araddr_s_hold", 64'(ARADDR_S[s*AB +: AB]), 64'(addr));
    ARREADY_S[s] = 1'b1;
    @(posedge clk); #1;
    ARREADY_S = '0;
  endtask

  // Runs nbeats R handshakes; releases the slave lines only once the whole burst is done
  task automatic r_phase(input int m, input int len, input logic [3:0] id, input int s,
                         input bit tog, input int nbeats);
    int b, cyc;
    logic rr;
    logic [31:0] d;
    logic [1:0] resp;
    b = 0;
    cyc = 0;
    resp = (s == 2) ? 2'b10 : 2'b00;
    while (b < nbeats && cyc < 80) begin
      rr = tog ? ((cyc % 2) == 0) : 1'b1;
      RREADY_M[m] = rr;
      d = 32'hD000_0000 | (32'(s) << 16) | (32'(id) << 8) | 32'(b);
      if (s >= 0) begin
        RVALID_S[s]            = 1'b1;
        RLAST_S[s]             = (b == len);
        RDATA_S[s*DB +: DB]    = d;
        RRESP_S[s*2 +: 2]      = resp;
        RID_S[s*IDSB +: IDSB]  = 8'((m << 4) | int'(id));
      end
      #1;
      chk("rvalid_m", 64'(RVALID_M), 64'(1) << m);
      chk("rdata_m", 64'(RDATA_M[m*DB +: DB]), (s >= 0) ? 64'(d) : 64'(0));
      chk("rresp_m", 64'(RRESP_M[m*2 +: 2]), (s >= 0) ? 64'(resp) : 64'(2'b11));
      chk("rid_m", 64'(RID_M[m*IDB +: IDB]), 64'(id));
      chk("rlast_m", 64'(RLAST_M), (b == len) ? (64'(1) << m) : 64'(0));
      chk("rready_s", 64'(RREADY_S), (s >= 0 && rr) ? (64'(1) << s) : 64'(0));
      chk("arready_m_busy", 64'(ARREADY_M), 64'(0));
      if (s < 0) chk("arvalid_s_derr", 64'(ARVALID_S), 64'(0));
      @(posedge clk); #1;
      if (rr) b++;
      cyc++;
    end
    if (b < nbeats) chk("r_timeout", 64'(b), 64'(nbeats));
    if (b > len) begin
      RVALID_S = '0;
      RLAST_S  = '0;
      RREADY_M = '0;
    end
  endtask

  task automatic run_burst(input int m, input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int s, input bit tog, input bit keep, output int w);
    ar_phase(m, addr, len, id, keep, w);
    if (s >= 0) addr_phase(m, addr, len, id, s);
    r_phase(m, len, id, s, tog, len + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    vt[0] = '{0, 32'h0001_0040,  3, 4'h3,  1, 1'b0};  // IM, 4 beats
    vt[1] = '{1, 32'h3000_0000,  2, 4'hA, -1, 1'b0};  // unmapped, 3 DECERR beats
    vt[2] = '{0, 32'h2000_0000,  5, 4'h7,  4, 1'b1};  // DRAM with RREADY toggling
    vt[3] = '{1, 32'h0000_1000,  0, 4'h1,  0, 1'b0};  // ROM, single beat
    vt[4] = '{0, 32'h0002_0010,  1, 4'hF,  2, 1'b0};  // DM, slave returns SLVERR
    vt[5] = '{1, 32'h1000_0000,  2, 4'h2,  3, 1'b1};  // sensor
    vt[6] = '{0, 32'h201F_FFFC,  0, 4'h4,  4, 1'b0};  // top of DRAM region
    vt[7] = '{1, 32'h2020_0000,  0, 4'h6, -1, 1'b0};  // just past DRAM
    vt[8] = '{0, 32'h1001_0000, 15, 4'h9, -1, 1'b1};  // unmapped, 16 beats

    ARID_M = '0; ARADDR_M = '0; ARLEN_M = '0; ARSIZE_M = '0; ARBURST_M = '0;
    RREADY_M = '0; ARREADY_S = '0; RID_S = '0; RDATA_S = '0; RRESP_S = '0;
    RLAST_S = '0; RVALID_S = '0;

    // Reset held with both masters requesting
    rst = 1'b1;
    set_ar(0, 32'h0001_0040, 3, 4'h3);
    set_ar(1, 32'h1000_0010, 1, 4'hB);
    ARVALID_M = 2'b11;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_arready_m", 64'(ARREADY_M), 64'(0));
      chk("rst_arvalid_s", 64'(ARVALID_S), 64'(0));
      chk("rst_rvalid_m", 64'(RVALID_M), 64'(0));
      chk("rst_rlast_m", 64'(RLAST_M), 64'(0));
    end
    rst = 1'b0;

    // Contention: M0 first after reset, then alternation with one IDLE cycle between bursts
    run_burst(0, 32'h0001_0040, 3, 4'h3, 1, 1'b0, 1'b1, w);
    chk("cont_wait0", 64'(w), 64'(0));
    run_burst(1, 32'h1000_0010, 1, 4'hB, 3, 1'b0, 1'b1, w);
    chk("cont_wait1", 64'(w), 64'(0));
    run_burst(0, 32'h0001_0040, 3, 4'h3, 1, 1'b0, 1'b0, w);
    chk("cont_wait2", 64'(w), 64'(0));
    ARVALID_M[1] = 1'b0;

    // Mid-burst reset on the second data beat
    ar_phase(1, 32'h0001_0000, 3, 4'h5, 1'b0, w);
    addr_phase(1, 32'h0001_0000, 3, 4'h5, 1);
    r_phase(1, 3, 4'h5, 1, 1'b0, 1);
    RVALID_S[1] = 1'b1;
    RREADY_M[1] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mrst_rvalid_m", 64'(RVALID_M), 64'(0));
    chk("mrst_rready_s", 64'(RREADY_S), 64'(0));
    chk("mrst_arvalid_s", 64'(ARVALID_S), 64'(0));
    chk("mrst_arready_m", 64'(ARREADY_M), 64'(0));
    chk("mrst_rlast_m", 64'(RLAST_M), 64'(0));
    chk("mrst_rdata_m", 64'(RDATA_M), 64'(0));
    RVALID_S = '0;
    RREADY_M = '0;
    RDATA_S  = '0;
    // Both request: rr_ptr was cleared by reset, so M0 wins before M1
    set_ar(1, 32'h0000_0100, 0, 4'hC);
    ARVALID_M[1] = 1'b1;
    run_burst(0, 32'h0002_0000, 1, 4'h8, 2, 1'b0, 1'b0, w);
    run_burst(1, 32'h0000_0100, 0, 4'hC, 0, 1'b0, 1'b0, w);

    // Table of independent bursts
    for (int k = 0; k < 9; k++) begin
      run_burst(vt[k].m, vt[k].addr, vt[k].len, vt[k].id, vt[k].s, vt[k].tog, 1'b0, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
